// File: rtl/string_hw_pkg.sv
// Shared types for the String_HW engine and its job scheduler.
package string_hw_pkg;

  localparam int STR_WORD_W  = 32;
  localparam int STR_FIELD_W = 3;

  typedef struct packed {
    logic [STR_WORD_W-1:0]  a;
    logic [STR_WORD_W-1:0]  b;
    logic [STR_FIELD_W-1:0] index;
    logic [STR_FIELD_W-1:0] length;
  } str_job_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } sched_state_e;

endpackage

// File: rtl/string_job_scheduler_if.sv
// Requester, response and engine signals of the job scheduler.
// slave: scheduler side; master: requesters plus engine side.
interface string_job_scheduler_if #(parameter int NREQ = 2);
  import string_hw_pkg::*;

  logic [NREQ-1:0]                  req_valid;
  logic [NREQ-1:0]                  req_ready;
  logic [NREQ-1:0][STR_WORD_W-1:0]  req_a;
  logic [NREQ-1:0][STR_WORD_W-1:0]  req_b;
  logic [NREQ-1:0][STR_FIELD_W-1:0] req_index;
  logic [NREQ-1:0][STR_FIELD_W-1:0] req_length;
  logic [NREQ-1:0]                  rsp_valid;
  logic [NREQ-1:0]                  rsp_ready;
  logic [STR_WORD_W-1:0]            rsp_result;
  logic                             rsp_timeout;
  logic                             eng_go;
  logic [STR_WORD_W-1:0]            eng_a;
  logic [STR_WORD_W-1:0]            eng_b;
  logic [STR_FIELD_W-1:0]           eng_index;
  logic [STR_FIELD_W-1:0]           eng_length;
  logic                             eng_done;
  logic [STR_WORD_W-1:0]            eng_result;

  modport slave (
    input  req_valid, req_a, req_b, req_index, req_length, rsp_ready, eng_done, eng_result,
    output req_ready, rsp_valid, rsp_result, rsp_timeout, eng_go, eng_a, eng_b, eng_index, eng_length
  );

  modport master (
    output req_valid, req_a, req_b, req_index, req_length, rsp_ready, eng_done, eng_result,
    input  req_ready, rsp_valid, rsp_result, rsp_timeout, eng_go, eng_a, eng_b, eng_index, eng_length
  );

endinterface

// File: rtl/string_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past last_grant_i.
module string_rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] last_grant_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [$clog2(NREQ)-1:0] gnt_idx_o,
  output logic                    gnt_valid_o
);

  localparam int IDX_W = $clog2(NREQ);

  logic [IDX_W-1:0] cand_s;

  // Walk candidates farthest-first so the nearest requester after last_grant_i wins.
  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    cand_s      = '0;
    for (int off = NREQ; off >= 1; off--) begin
      cand_s = IDX_W'((int'(last_grant_i) + off) % NREQ);
      if (req_i[cand_s]) begin
        gnt_o         = '0;
        gnt_o[cand_s] = 1'b1;
        gnt_idx_o     = cand_s;
        gnt_valid_o   = 1'b1;
      end else begin
        gnt_valid_o = gnt_valid_o;
      end
    end
  end

endmodule

// File: rtl/string_job_scheduler.sv
// Shares one String_HW engine between NREQ requesters, round-robin.
// Optional RUN watchdog: define STRSCHED_TIMEOUT_EN.
module string_job_scheduler
  import string_hw_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  string_job_scheduler_if.slave  sif
);

  localparam int IDX_W = $clog2(NREQ);

  sched_state_e     state_q, state_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  str_job_t         job_q, job_d;
  logic [STR_WORD_W-1:0] result_q, result_d;
  logic             timeout_q, timeout_d;

  logic [NREQ-1:0]  arb_gnt_s;
  logic [IDX_W-1:0] arb_idx_s;
  logic             arb_any_s;
  logic             timeout_hit_s;
  logic [NREQ-1:0]  req_ready_s;
  logic [NREQ-1:0]  rsp_valid_s;
  logic             eng_go_s;

  string_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i       (sif.req_valid),
    .last_grant_i(last_grant_q),
    .gnt_o       (arb_gnt_s),
    .gnt_idx_o   (arb_idx_s),
    .gnt_valid_o (arb_any_s)
  );

`ifdef STRSCHED_TIMEOUT_EN
  localparam logic [15:0] TLIMIT = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tcnt_q, tcnt_d;

  // RUN-cycle counter; held at zero outside RUN so it is clear on entry.
  always_comb begin
    tcnt_d = 16'd0;
    if (state_q == ST_RUN) tcnt_d = tcnt_q + 16'd1;
    else                   tcnt_d = 16'd0;
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tcnt_q <= 16'd0;
    else       tcnt_q <= tcnt_d;
  end

  assign timeout_hit_s = (state_q == ST_RUN) && (tcnt_q == TLIMIT);
`else
  // Without the watchdog RUN waits forever; the limit parameter is inert.
  assign timeout_hit_s = (TIMEOUT_CYCLES < 0);
`endif

  // Next-state, job latch and handshake outputs.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    job_d        = job_q;
    result_d     = result_q;
    timeout_d    = timeout_q;
    req_ready_s  = '0;
    rsp_valid_s  = '0;
    eng_go_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!reset) req_ready_s = arb_gnt_s;
        else        req_ready_s = '0;
        if (arb_any_s) begin
          job_d.a      = sif.req_a[arb_idx_s];
          job_d.b      = sif.req_b[arb_idx_s];
          job_d.index  = sif.req_index[arb_idx_s];
          job_d.length = sif.req_length[arb_idx_s];
          grant_d      = arb_idx_s;
          last_grant_d = arb_idx_s;
          state_d      = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        eng_go_s = 1'b1;
        // A done arriving on the limit cycle takes precedence over the abort.
        if (sif.eng_done) begin
          result_d  = sif.eng_result;
          timeout_d = 1'b0;
          state_d   = ST_RESP;
        end else if (timeout_hit_s) begin
          result_d  = '0;
          timeout_d = 1'b1;
          state_d   = ST_RESP;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RESP: begin
        rsp_valid_s[grant_q] = 1'b1;
        if (sif.rsp_ready[grant_q]) state_d = ST_DRAIN;
        else                        state_d = ST_RESP;
      end
      ST_DRAIN: begin
        // Wait for the engine to drop done so the next go is a clean rising level.
        if (!sif.eng_done) state_d = ST_IDLE;
        else               state_d = ST_DRAIN;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IDX_W'(NREQ - 1);
      grant_q      <= '0;
      job_q        <= '0;
      result_q     <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      job_q        <= job_d;
      result_q     <= result_d;
      timeout_q    <= timeout_d;
    end
  end

  assign sif.req_ready   = req_ready_s;
  assign sif.rsp_valid   = rsp_valid_s;
  assign sif.eng_go      = eng_go_s;
  assign sif.rsp_result  = result_q;
  assign sif.rsp_timeout = timeout_q;
  assign sif.eng_a       = job_q.a;
  assign sif.eng_b       = job_q.b;
  assign sif.eng_index   = job_q.index;
  assign sif.eng_length  = job_q.length;

endmodule

// File: tb/tb_string_job_scheduler.sv
// Self-checking bench for string_job_scheduler with a behavioural engine.
module tb_string_job_scheduler;
  import string_hw_pkg::*;

  localparam int NREQ = 2;
  localparam int TC   = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  string_job_scheduler_if #(.NREQ(NREQ)) sif ();

  string_job_scheduler #(.NREQ(NREQ), .TIMEOUT_CYCLES(TC)) dut (
    .clk  (clk),
    .reset(reset),
    .sif  (sif)
  );

  int checks   = 0;
  int failures = 0;

  // Requester-side job store and round-robin reference state.
  bit          pend [NREQ];
  logic [31:0] pa   [NREQ];
  logic [31:0] pb   [NREQ];
  logic [2:0]  pidx [NREQ];
  logic [2:0]  plen [NREQ];
  int          last_w;
  bit          refill_all;

  // Engine model controls.
  int          eng_lat  = 5;
  int          eng_hold = 0;
  int          go_cnt;
  int          hold_cnt;
  bit          fixed_en = 1'b0;
  logic [31:0] fixed_val = 32'h0;

  function automatic logic [31:0] ref_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] ix, input logic [2:0] ln);
    return (a ^ {b[15:0], b[31:16]}) + {26'd0, ix, ln};
  endfunction

  assign sif.eng_result = fixed_en ? fixed_val
                        : ref_fn(sif.eng_a, sif.eng_b, sif.eng_index, sif.eng_length);

  // Engine: raise done eng_lat cycles after go rises, release it eng_hold cycles after go drops.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sif.eng_done <= 1'b0;
      go_cnt       <= 0;
      hold_cnt     <= 0;
    end else if (sif.eng_go) begin
      hold_cnt <= 0;
      go_cnt   <= go_cnt + 1;
      if (go_cnt + 1 == eng_lat) sif.eng_done <= 1'b1;
    end else begin
      go_cnt <= 0;
      if (sif.eng_done) begin
        hold_cnt <= hold_cnt + 1;
        if (hold_cnt + 1 >= eng_hold) sif.eng_done <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_job(input int k);
    pa[k]   = $urandom;
    pb[k]   = $urandom;
    pidx[k] = 3'($urandom_range(7));
    plen[k] = 3'($urandom_range(7));
    pend[k] = 1'b1;
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      sif.req_valid[i]  = pend[i];
      sif.req_a[i]      = pa[i];
      sif.req_b[i]      = pb[i];
      sif.req_index[i]  = pidx[i];
      sif.req_length[i] = plen[i];
    end
    #1;
  endtask

  function automatic int model_pick();
    for (int off = 1; off <= NREQ; off++)
      if (pend[(last_w + off) % NREQ]) return (last_w + off) % NREQ;
    return -1;
  endfunction

  function automatic int ready_idx();
    for (int i = 0; i < NREQ; i++) if (sif.req_ready[i]) return i;
    return -1;
  endfunction

  // One complete job: arbitration, run, response (with optional backpressure) and drain.
  task automatic serve_one(input int lat, input int hold, input int rdelay, input bit early,
                           input bit expect_to, output int winner);
    int exp_w, waited, n, exp_n;
    logic [31:0] ja, jb, exp_res;
    logic [2:0]  jx, jl;
    logic [NREQ-1:0] oh;
    eng_lat  = lat;
    eng_hold = hold;
    if (!pend[0] && !pend[1]) new_job($urandom_range(NREQ - 1));
    drive_reqs();
    exp_w  = model_pick();
    waited = 0;
    while (sif.req_ready == '0 && waited < 50) begin
      @(negedge clk); drive_reqs(); waited++;
    end
    oh = '0; oh[exp_w] = 1'b1;
    chk("grant", sif.req_ready, oh);
    winner = ready_idx();
    ja = pa[exp_w]; jb = pb[exp_w]; jx = pidx[exp_w]; jl = plen[exp_w];
    last_w = exp_w;
    @(negedge clk);
    pend[exp_w] = 1'b0;
    for (int i = 0; i < NREQ; i++)
      if (!pend[i] && (refill_all || $urandom_range(1) == 1)) new_job(i);
    drive_reqs();
    if (early) sif.rsp_ready[exp_w] = 1'b1;
    chk("run_go", sif.eng_go, 1'b1);
    chk("run_a", sif.eng_a, ja);
    chk("run_b", sif.eng_b, jb);
    chk("run_fields", {sif.eng_index, sif.eng_length}, {jx, jl});
    chk("run_no_ready", sif.req_ready, '0);
    n = 1;
    while (sif.rsp_valid == '0 && n < (expect_to ? TC : lat) + 10) begin
      @(negedge clk); n++;
    end
    exp_n   = expect_to ? TC + 1 : lat + 2;
    exp_res = expect_to ? 32'h0 : (fixed_en ? fixed_val : ref_fn(ja, jb, jx, jl));
    chk("rsp_latency", n, exp_n);
    chk("rsp_valid", sif.rsp_valid, oh);
    chk("rsp_result", sif.rsp_result, exp_res);
    chk("rsp_timeout", sif.rsp_timeout, expect_to);
    chk("resp_go_low", sif.eng_go, 1'b0);
    for (int k = 0; k < (early ? 0 : rdelay); k++) begin
      @(negedge clk);
      chk("hold_valid", sif.rsp_valid, oh);
      chk("hold_result", sif.rsp_result, exp_res);
      chk("hold_go", sif.eng_go, 1'b0);
      chk("hold_no_ready", sif.req_ready, '0);
    end
    sif.rsp_ready[exp_w] = 1'b1;
    @(negedge clk);
    sif.rsp_ready = '0;
    #1;
    chk("drain_valid", sif.rsp_valid, '0);
    chk("drain_go", sif.eng_go, 1'b0);
    waited = 0;
    while (sif.eng_done && waited < 20) begin
      chk("drain_block", sif.req_ready, '0);
      @(negedge clk); waited++;
    end
    chk("drain_last", sif.req_ready, '0);
    @(negedge clk);
    drive_reqs();
    if (pend[0] || pend[1]) begin
      oh = '0; oh[model_pick()] = 1'b1;
      chk("reaccept", sif.req_ready, oh);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    sif.rsp_ready = '0;
    drive_reqs();
    last_w = NREQ - 1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    int w;
    int got [4];
    int exp_seq [4];
    logic [NREQ-1:0] oh;
    exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 0; exp_seq[3] = 1;
    refill_all = 1'b0;

    // Reset values.
    reset = 1'b1;
    #2;
    chk("rst_ready", sif.req_ready, '0);
    chk("rst_valid", sif.rsp_valid, '0);
    chk("rst_go", sif.eng_go, 1'b0);
    chk("rst_result", sif.rsp_result, 32'h0);
    chk("rst_ab", {sif.eng_a, sif.eng_b}, 64'h0);
    chk("rst_fields", {sif.eng_index, sif.eng_length}, 6'h0);
    chk("rst_timeout", sif.rsp_timeout, 1'b0);
    do_reset();

    // Single job on requester 0 with a fixed engine result.
    pa[0] = 32'h41424344; pb[0] = 32'h61626364; pidx[0] = 3'd2; plen[0] = 3'd3; pend[0] = 1'b1;
    fixed_en = 1'b1; fixed_val = 32'hDEADBEEF;
    serve_one(5, 0, 0, 1'b0, 1'b0, w);
    fixed_en = 1'b0;

    // Contention from reset: both requesters always offering.
    do_reset();
    refill_all = 1'b1;
    new_job(0); new_job(1);
    for (int j = 0; j < 4; j++) begin
      serve_one(2 + j, j, j % 2, 1'b0, 1'b0, w);
      got[j] = w;
    end
    for (int j = 0; j < 4; j++) chk("contention_order", got[j], exp_seq[j]);

    // Backpressure for 10 cycles and slow done release with others waiting.
    serve_one(3, 2, 10, 1'b0, 1'b0, w);
    serve_one(4, 3, 0, 1'b0, 1'b0, w);
    serve_one(1, 0, 0, 1'b1, 1'b0, w);
    refill_all = 1'b0;

`ifdef STRSCHED_TIMEOUT_EN
    // Watchdog abort, then done on the limit cycle, then a normal job.
    serve_one(100000, 0, 1, 1'b0, 1'b1, w);
    serve_one(TC - 1, 1, 0, 1'b0, 1'b0, w);
    serve_one(3, 0, 0, 1'b0, 1'b0, w);
`endif

    // Randomized jobs.
    for (int j = 0; j < 20; j++)
      serve_one($urandom_range(8, 1), $urandom_range(4), $urandom_range(3),
                ($urandom_range(3) == 0), 1'b0, w);

    // Reset during RUN.
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    new_job(1);
    eng_lat = 1000;
    drive_reqs();
    w = 0;
    while (sif.req_ready == '0 && w < 50) begin @(negedge clk); drive_reqs(); w++; end
    oh = '0; oh[model_pick()] = 1'b1;
    chk("rr_grant_before_reset", sif.req_ready, oh);
    @(negedge clk);
    pend[1] = 1'b0;
    new_job(0); new_job(1);
    drive_reqs();
    repeat (3) @(negedge clk);
    chk("run_before_reset", sif.eng_go, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_go", sif.eng_go, 1'b0);
    chk("rst_mid_valid", sif.rsp_valid, '0);
    chk("rst_mid_ready", sif.req_ready, '0);
    chk("rst_mid_a", sif.eng_a, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    last_w = NREQ - 1;
    #1;
    chk("post_reset_grant", sif.req_ready, 2'b01);
    serve_one(2, 0, 0, 1'b0, 1'b0, w);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
